// File: rtl/mem_access_ctrl.sv
// Memory-side sequencer: holds MAR/MDR and turns one-cycle read/write requests into RAM strobes.
// Optional MAR auto-increment after every completed access: define MEM_MAR_AUTOINC_EN.
module mem_access_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] MDR_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_LATCH,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_mar;
    logic [ADDR_W-1:0]   r_accAddr;
    logic [DATA_W-1:0]   r_mdr;
    logic [3:0]          r_waitCnt;

    // r_accAddr snapshots the pre-load MAR so an access issued together with MARin uses the old address.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_mar     <= '0;
            r_accAddr <= '0;
            r_mdr     <= '0;
            r_waitCnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MARin) r_mar <= BusMuxOut[ADDR_W-1:0];
                    if (MDRin) r_mdr <= BusMuxOut;
                    r_accAddr <= r_mar;
                    if (wr_req)      r_state <= S_WR_ISSUE;
                    else if (rd_req) r_state <= S_RD_ISSUE;
                end
                S_WR_ISSUE: begin
                    r_state <= S_DONE;
                end
                S_RD_ISSUE: begin
                    r_waitCnt <= '0;
                    r_state   <= (RD_WAIT > 0) ? S_RD_WAIT : S_RD_LATCH;
                end
                S_RD_WAIT: begin
                    if (r_waitCnt == WAIT_LAST) begin
                        r_state <= S_RD_LATCH;
                    end else begin
                        r_waitCnt <= r_waitCnt + 4'd1;
                    end
                end
                S_RD_LATCH: begin
                    r_mdr   <= MDataIn;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
`ifdef MEM_MAR_AUTOINC_EN
                    r_mar   <= r_mar + ADDR_W'(1);
`else
                    r_mar   <= r_mar;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes and status come straight from the state register, so they never glitch.
    assign ram_addr  = (r_state == S_IDLE) ? r_mar : r_accAddr;
    assign ram_read  = (r_state == S_RD_ISSUE);
    assign ram_write = (r_state == S_WR_ISSUE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign ram_wdata = r_mdr;
    assign MDR_out   = r_mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: transaction-level model of MAR/MDR/RAM, decoupled monitor.
// Honours MEM_MAR_AUTOINC_EN when the same define is given to the bench.
module tb_mem_access_ctrl;

    typedef struct {
        logic        isWrite;
        logic [8:0]  addr;
        logic [31:0] data;
        int          cycle;
    } strobe_t;

    typedef struct {
        logic [31:0] mdr;
        int          cycle;
    } done_t;

    logic        clock = 1'b0;
    logic        clear, MARin, MDRin, rd_req, wr_req;
    logic [31:0] BusMuxOut, MDataIn;
    logic [8:0]  ram_addr;
    logic        ram_read, ram_write, busy, done;
    logic [31:0] ram_wdata, MDR_out;

    logic        clear3, MARin3, MDRin3, rd_req3, wr_req3;
    logic [31:0] BusMuxOut3, MDataIn3;
    logic [8:0]  ram_addr3;
    logic        ram_read3, ram_write3, busy3, done3;
    logic [31:0] ram_wdata3, MDR_out3;

    logic [31:0] ram    [512];
    logic [31:0] ram3   [512];
    logic [31:0] refMem [512];
    logic [8:0]  refMar;
    logic [31:0] refMdr;

    strobe_t strobeQ[$];
    done_t   doneQ[$];
    strobe_t monS;
    done_t   monD;

    int cycleCnt  = 0;
    int testsRun  = 0;
    int failures  = 0;

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RD_WAIT(0)) dut (
        .clock(clock), .clear(clear), .MARin(MARin), .MDRin(MDRin),
        .rd_req(rd_req), .wr_req(wr_req), .BusMuxOut(BusMuxOut), .MDataIn(MDataIn),
        .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
        .ram_wdata(ram_wdata), .MDR_out(MDR_out), .busy(busy), .done(done)
    );

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RD_WAIT(3)) dut3 (
        .clock(clock), .clear(clear3), .MARin(MARin3), .MDRin(MDRin3),
        .rd_req(rd_req3), .wr_req(wr_req3), .BusMuxOut(BusMuxOut3), .MDataIn(MDataIn3),
        .ram_addr(ram_addr3), .ram_read(ram_read3), .ram_write(ram_write3),
        .ram_wdata(ram_wdata3), .MDR_out(MDR_out3), .busy(busy3), .done(done3)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt = cycleCnt + 1;

    // Synchronous RAMs with registered read data, one per DUT.
    always @(posedge clock) begin
        if (ram_write) ram[ram_addr] <= ram_wdata;
        if (ram_read)  MDataIn <= ram[ram_addr];
        if (ram_write3) ram3[ram_addr3] <= ram_wdata3;
        if (ram_read3)  MDataIn3 <= ram3[ram_addr3];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe and done pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (ram_write === 1'b1 || ram_read === 1'b1) begin
            if (strobeQ.size() == 0) begin
                checkOutput("unexpected strobe", {30'd0, ram_write, ram_read}, 32'd0);
            end else begin
                monS = strobeQ.pop_front();
                checkOutput("strobe kind", {30'd0, ram_write, ram_read}, monS.isWrite ? 32'd2 : 32'd1);
                checkOutput("strobe addr", 32'(ram_addr), 32'(monS.addr));
                checkOutput("strobe cycle", 32'(cycleCnt), 32'(monS.cycle));
                if (monS.isWrite) checkOutput("write data", ram_wdata, monS.data);
            end
        end
        if (done === 1'b1) begin
            if (doneQ.size() == 0) begin
                checkOutput("unexpected done", 32'(done), 32'd0);
            end else begin
                monD = doneQ.pop_front();
                checkOutput("done mdr", MDR_out, monD.mdr);
                checkOutput("done cycle", 32'(cycleCnt), 32'(monD.cycle));
            end
        end
    end

    task automatic idleCheck();
        checkOutput("idle busy", 32'(busy), 32'd0);
        checkOutput("idle mar", 32'(ram_addr), 32'(refMar));
        checkOutput("idle mdr", MDR_out, refMdr);
        checkOutput("idle wdata", ram_wdata, refMdr);
    endtask

    // Drives one IDLE cycle of inputs, updates the model and waits until the DUT is idle again.
    task automatic applyStimulus(input logic mIn, input logic dIn, input logic rd, input logic wr,
                                 input logic [31:0] bus, input logic noise);
        logic [8:0] oldMar;
        int issue;
        int n;
        idleCheck();
        oldMar = refMar;
        issue  = cycleCnt + 1;
        MARin = mIn; MDRin = dIn; rd_req = rd; wr_req = wr; BusMuxOut = bus;
        if (mIn) refMar = bus[8:0];
        if (dIn) refMdr = bus;
        if (wr) begin
            refMem[oldMar] = refMdr;
            strobeQ.push_back('{1'b1, oldMar, refMdr, issue});
            doneQ.push_back('{refMdr, issue + 1});
        end else if (rd) begin
            refMdr = refMem[oldMar];
            strobeQ.push_back('{1'b0, oldMar, 32'd0, issue});
            doneQ.push_back('{refMdr, issue + 2});
        end
`ifdef MEM_MAR_AUTOINC_EN
        if (wr || rd) refMar = refMar + 9'd1;
`endif
        n = wr ? 3 : (rd ? 4 : 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            if (i == 0) begin
                MARin = 0; MDRin = 0; rd_req = 0; wr_req = 0; BusMuxOut = 0;
                if (noise) begin
                    rd_req = 1; MDRin = 1; MARin = 1; BusMuxOut = 32'hFFFF;
                end
            end else if (i == 1) begin
                MARin = 0; MDRin = 0; rd_req = 0; BusMuxOut = 0;
            end
        end
    endtask

    // Read abandoned by clear during the MDR capture cycle.
    task automatic clearMidRead();
        int issue;
        idleCheck();
        issue  = cycleCnt + 1;
        rd_req = 1;
        strobeQ.push_back('{1'b0, refMar, 32'd0, issue});
        @(posedge clock); #1;
        rd_req = 0;
        @(posedge clock); #1;
        clear = 1;
        @(posedge clock); #1;
        clear = 0;
        refMar = 9'd0;
        refMdr = 32'd0;
        checkOutput("clear busy", 32'(busy), 32'd0);
        checkOutput("clear mdr", MDR_out, 32'd0);
        @(posedge clock); #1;
        idleCheck();
    endtask

    initial begin
        logic [31:0] rb;
        logic        b;
        int          op;
        int          readCount, readAt, doneCount, doneAt;
        logic [31:0] mdrAtDone;

        for (int i = 0; i < 512; i++) begin
            ram[i]    = $urandom;
            refMem[i] = ram[i];
            ram3[i]   = 32'd0;
        end
        ram[95]    = 32'h0004;
        refMem[95] = 32'h0004;
        ram3[5]    = 32'hC0DE0005;

        clear = 1; MARin = 1; MDRin = 0; rd_req = 1; wr_req = 0; BusMuxOut = 32'h1234;
        clear3 = 1; MARin3 = 0; MDRin3 = 0; rd_req3 = 0; wr_req3 = 0; BusMuxOut3 = 0;
        repeat (2) @(posedge clock);
        #1;
        clear = 0; MARin = 0; rd_req = 0; BusMuxOut = 0; clear3 = 0;
        refMar = 9'd0;
        refMdr = 32'd0;
        checkOutput("reset mar", 32'(ram_addr), 32'd0);
        checkOutput("reset mdr", MDR_out, 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset ram_read", 32'(ram_read), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);

        applyStimulus(1, 0, 0, 0, 32'd95, 0);
        applyStimulus(0, 0, 1, 0, 32'd0, 0);
        checkOutput("read 95", MDR_out, 32'h0004);

        applyStimulus(1, 0, 0, 0, 32'd87, 0);
        applyStimulus(0, 1, 0, 0, 32'hABBA, 0);
        applyStimulus(0, 0, 0, 1, 32'd0, 0);
        applyStimulus(1, 0, 0, 0, 32'd87, 0);
        applyStimulus(0, 0, 1, 0, 32'd0, 0);
        checkOutput("readback 87", MDR_out, 32'hABBA);

        applyStimulus(1, 0, 0, 0, 32'd200, 0);
        applyStimulus(0, 1, 0, 0, 32'h5555AAAA, 0);
        applyStimulus(0, 0, 1, 1, 32'd0, 0);

        applyStimulus(1, 0, 0, 0, 32'd95, 0);
        applyStimulus(0, 0, 1, 0, 32'd0, 1);
        checkOutput("ignored mdrin", MDR_out, 32'h0004);

        applyStimulus(1, 0, 0, 0, 32'd87, 0);
        applyStimulus(1, 0, 1, 0, 32'd95, 0);
        checkOutput("old mar used", MDR_out, 32'hABBA);

        applyStimulus(1, 0, 0, 0, 32'hFFFFFE05, 0);
        checkOutput("mar truncate", 32'(ram_addr), 32'd5);

        applyStimulus(1, 0, 0, 0, 32'd511, 0);
        applyStimulus(0, 0, 1, 0, 32'd0, 0);
`ifdef MEM_MAR_AUTOINC_EN
        checkOutput("mar after 511", 32'(ram_addr), 32'd0);
`else
        checkOutput("mar after 511", 32'(ram_addr), 32'd511);
`endif

        applyStimulus(1, 1, 0, 0, 32'h00000123, 0);
        clearMidRead();

        for (int k = 0; k < 80; k++) begin
            op = int'($urandom_range(0, 5));
            rb = $urandom;
            b  = 1'($urandom_range(0, 1));
            if (b) rb[8:3] = 6'd0;
            case (op)
                0: applyStimulus(1, 0, 0, 0, rb, 0);
                1: applyStimulus(0, 1, 0, 0, rb, 0);
                2: applyStimulus(0, b, 1, 0, rb, 0);
                3: applyStimulus(0, 0, 0, 1, rb, 0);
                4: applyStimulus(0, 0, 1, 1, rb, b);
                default: applyStimulus(1, 0, 1, 0, rb, 0);
            endcase
        end
        idleCheck();

        // RD_WAIT = 3 instance: read latency stretched by three idle cycles.
        @(posedge clock); #1;
        MARin3 = 1; BusMuxOut3 = 32'd5;
        @(posedge clock); #1;
        MARin3 = 0; BusMuxOut3 = 0; rd_req3 = 1;
        @(posedge clock); #1;
        rd_req3 = 0;
        readCount = 0; readAt = 0; doneCount = 0; doneAt = 0; mdrAtDone = 32'd0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (ram_read3 === 1'b1) begin
                readCount++;
                readAt = n;
            end
            if (done3 === 1'b1) begin
                doneCount++;
                doneAt = n;
                mdrAtDone = MDR_out3;
            end
        end
        checkOutput("wait3 read count", 32'(readCount), 32'd1);
        checkOutput("wait3 read cycle", 32'(readAt), 32'd1);
        checkOutput("wait3 done count", 32'(doneCount), 32'd1);
        checkOutput("wait3 done cycle", 32'(doneAt), 32'd6);
        checkOutput("wait3 mdr", mdrAtDone, 32'hC0DE0005);
        checkOutput("wait3 busy", 32'(busy3), 32'd0);

        repeat (5) @(posedge clock);
        #1;
        checkOutput("strobes pending", 32'(strobeQ.size()), 32'd0);
        checkOutput("dones pending", 32'(doneQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
